seven_seg: RTL and testbench

//  - Converts a 6-bit unsigned score (0..63) into two decimal digits and drives two 7-segment displays.
//  - Sits at the output of the blackjack datapath, after the magnitude/score result.
//  - Drives board-level HEX displays.
//  - Outputs are registered and synchronous to clk.

---
 rtl/seven_seg_pkg.sv | 10 +
 rtl/seven_seg_digit.sv | 13 +
 rtl/seven_seg.sv | 53 +++++
 tb/tb_seven_seg.sv | 122 ++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: shared types and segment patterns for the two-digit score display
package seven_seg_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;
  localparam seg_t SEG_BLANK = 7'b1111111;
  localparam seg_t SEG_LUT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
endpackage

// File: rtl/seven_seg_digit.sv
// seven_seg_digit: combinational decimal digit to 7-segment decoder, codes 10..15 blank
module seven_seg_digit
  import seven_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  digit_t digit,
  output seg_t   seg
);
  seg_t pat;
  assign pat = (digit > 4'd9) ? SEG_BLANK : SEG_LUT[digit];
  assign seg = (ACTIVE_LOW != 0) ? pat : ~pat;
endmodule

// File: rtl/seven_seg.sv
// seven_seg: registered 0..63 score to two 7-segment digits; SEVEN_SEG_LEADING_ZERO_BLANK_EN blanks a zero tens digit
module seven_seg
  import seven_seg_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] mag_result,
  output logic [6:0] seg1,
  output logic [6:0] seg2
);
  localparam seg_t DARK = (ACTIVE_LOW != 0) ? SEG_BLANK : ~SEG_BLANK;
  digit_t tens;
  digit_t ones;
  logic [5:0] sub;
  seg_t ones_seg;
  seg_t tens_seg;
  seg_t seg2_next;
  // binary to BCD split by compare against multiples of ten, then subtract
  always_comb begin
    tens = (mag_result >= 6'd60) ? 4'd6 :
           (mag_result >= 6'd50) ? 4'd5 :
           (mag_result >= 6'd40) ? 4'd4 :
           (mag_result >= 6'd30) ? 4'd3 :
           (mag_result >= 6'd20) ? 4'd2 :
           (mag_result >= 6'd10) ? 4'd1 : 4'd0;
    sub  = (mag_result >= 6'd60) ? 6'd60 :
           (mag_result >= 6'd50) ? 6'd50 :
           (mag_result >= 6'd40) ? 6'd40 :
           (mag_result >= 6'd30) ? 6'd30 :
           (mag_result >= 6'd20) ? 6'd20 :
           (mag_result >= 6'd10) ? 6'd10 : 6'd0;
    ones = 4'(mag_result - sub);
  end
  seven_seg_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_ones (.digit(ones), .seg(ones_seg));
  seven_seg_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_tens (.digit(tens), .seg(tens_seg));
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  assign seg2_next = (tens == 4'd0) ? DARK : tens_seg;
`else
  assign seg2_next = tens_seg;
`endif
  // output register; reset darkens both displays immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg1 <= DARK;
      seg2 <= DARK;
    end else begin
      seg1 <= ones_seg;
      seg2 <= seg2_next;
    end
  end
endmodule

// File: tb/tb_seven_seg.sv
// tb_seven_seg: vector table, corner sequences and random/exhaustive checks of seven_seg against a /10 %10 model
module tb_seven_seg;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] mag_result = 6'd0;
  logic [6:0] seg1;
  logic [6:0] seg2;
  int total = 0;
  int bad = 0;

  seven_seg dut (.clk(clk), .rst_n(rst_n), .mag_result(mag_result), .seg1(seg1), .seg2(seg2));

  always #5 clk = ~clk;

  localparam logic [6:0] BL = 7'b1111111;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] Z2 = BL;
  localparam bit LZB = 1'b1;
`else
  localparam logic [6:0] Z2 = 7'b1000000;
  localparam bit LZB = 1'b0;
`endif

  logic [6:0] pats [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  typedef struct {
    logic [5:0] v;
    logic [6:0] s1;
    logic [6:0] s2;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string name, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  function automatic logic [6:0] ref1(input int v);
    return pats[v % 10];
  endfunction

  function automatic logic [6:0] ref2(input int v);
    return (LZB && v < 10) ? BL : pats[v / 10];
  endfunction

  task automatic apply_chk(input int v, input string name);
    mag_result = 6'(v);
    @(negedge clk);
    chk({name, ".seg1"}, seg1, ref1(v));
    chk({name, ".seg2"}, seg2, ref2(v));
  endtask

  initial begin
    tbl[0] = '{6'd0,  7'b1000000, Z2};
    tbl[1] = '{6'd9,  7'b0010000, Z2};
    tbl[2] = '{6'd10, 7'b1000000, 7'b1111001};
    tbl[3] = '{6'd17, 7'b1111000, 7'b1111001};
    tbl[4] = '{6'd21, 7'b1111001, 7'b0100100};
    tbl[5] = '{6'd31, 7'b1111001, 7'b0110000};
    tbl[6] = '{6'd63, 7'b0110000, 7'b0000010};
    tbl[7] = '{6'd45, 7'b0010010, 7'b0011001};
    tbl[8] = '{6'd58, 7'b0000000, 7'b0010010};

    mag_result = 6'd17;
    repeat (2) @(negedge clk);
    chk("reset.seg1", seg1, BL);
    chk("reset.seg2", seg2, BL);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release.seg1", seg1, 7'b1111000);
    chk("release.seg2", seg2, 7'b1111001);

    foreach (tbl[i]) begin
      mag_result = tbl[i].v;
      @(negedge clk);
      chk($sformatf("vec%0d.seg1", tbl[i].v), seg1, tbl[i].s1);
      chk($sformatf("vec%0d.seg2", tbl[i].v), seg2, tbl[i].s2);
    end

    mag_result = 6'd9;
    @(negedge clk);
    mag_result = 6'd10;
    chk("b2b9.seg1", seg1, 7'b0010000);
    chk("b2b9.seg2", seg2, Z2);
    @(negedge clk);
    mag_result = 6'd11;
    chk("b2b10.seg1", seg1, 7'b1000000);
    chk("b2b10.seg2", seg2, 7'b1111001);
    @(negedge clk);
    chk("b2b11.seg1", seg1, 7'b1111001);
    chk("b2b11.seg2", seg2, 7'b1111001);

    mag_result = 6'd21;
    @(negedge clk);
    chk("pre_rst.seg1", seg1, 7'b1111001);
    chk("pre_rst.seg2", seg2, 7'b0100100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.seg1", seg1, BL);
    chk("async_rst.seg2", seg2, BL);
    @(negedge clk);
    chk("held_rst.seg1", seg1, BL);
    chk("held_rst.seg2", seg2, BL);
    rst_n = 1'b1;

    for (int v = 0; v < 64; v++) apply_chk(v, $sformatf("ex%0d", v));
    for (int k = 0; k < 200; k++) begin
      int v;
      v = int'($urandom_range(63));
      apply_chk(v, $sformatf("rnd%0d_%0d", k, v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
